fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that sits directly upstream of the 8-bit instruction register.
- Owns the program counter and runs a request/acknowledge handshake with instruction memory.
- Drives the register's write-enable and data inputs with each fetched byte.
- Supports back-pressure from the decode stage and branch redirects, including a redirect that arrives mid-fetch.

Parameters:
- ADDR_W, 8, program-counter and memory-address width.
- DATA_W, 8, instruction byte width; must match the instruction register width.
- RESET_PC, 0, PC value loaded on reset.
- MAX_WAIT, 15, wait-cycle limit in REQ; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- en_i  in  1  run enable; permits starting a new fetch.
- stall_i  in  1  decode busy; blocks starting a new fetch.
- branch_i  in  1  redirect request.
- branch_addr_i  in  ADDR_W  redirect target.
- mem_req_o  out  1  memory request; held high until acknowledged.
- mem_addr_o  out  ADDR_W  fetch address; always equals the PC.
- mem_ack_i  in  1  memory acknowledge; mem_data_i is valid in the same cycle.
- mem_data_i  in  DATA_W  fetched byte.
- ir_wen_o  out  1  instruction register write enable; one-cycle pulse.
- ir_d_o  out  DATA_W  instruction register data.
- pc_o  out  ADDR_W  current PC.
- fault_o  out  1  fetch timeout flag; tied to 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-high, effective immediately, including mid-request):
  - state = IDLE, pc = RESET_PC.
  - mem_req_o, ir_wen_o and fault_o = 0; ir_d_o = 0.
  - Pending-branch flag and wait counter cleared.
- States: IDLE, REQ, LOAD, FAULT. Encodings are defined in the package.
- IDLE:
  - branch_i=1 loads pc = branch_addr_i.
  - en_i=1 and stall_i=0 moves to REQ next cycle.
- REQ:
  - mem_req_o=1 and mem_addr_o=pc, held stable until mem_ack_i.
  - On mem_ack_i: latch mem_data_i, then go to LOAD.
  - Zero-wait memory: en_i rises in cycle 0, request in cycle 1, ir_wen_o in cycle 2.
  - en_i or stall_i changing while in REQ does not abort the outstanding request.
- Branch during REQ:
  - Record branch_addr_i as a pending target; the last redirect before the ack wins.
  - On ack the fetched byte is discarded: go to IDLE, not LOAD, with no ir_wen_o.
  - pc = pending target and the flag is cleared.
- LOAD:
  - ir_wen_o=1 for exactly one cycle; ir_d_o = latched byte.
  - pc = branch_i ? branch_addr_i : pc+1, modulo 2^ADDR_W (0xFF+1 = 0x00).
  - Next state is REQ if en_i=1 and stall_i=0, otherwise IDLE.
- ir_d_o holds its last value outside LOAD.
- mem_ack_i outside REQ is ignored.
- pc_o = pc, which is also mem_addr_o.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter increments each REQ cycle without an ack.
  - On reaching MAX_WAIT, go to FAULT: mem_req_o=0 and fault_o=1.
  - FAULT is sticky and ignores all inputs until rst_i.
  - The counter clears on entry to REQ.
- Undefined: no counter and no FAULT state; REQ waits indefinitely; fault_o=0.

Decomposition:
- Shared package angstrom_pkg holds:
  - state encodings: IDLE=2'b00, REQ=2'b01, LOAD=2'b10, FAULT=2'b11;
  - default widths ADDR_W and DATA_W.
- One sub-module, pc_counter:
  - ADDR_W-bit register with asynchronous reset to RESET_PC;
  - load has priority over increment;
  - wraps on overflow.
- FSM, data latch and branch-pending logic stay in fetch_ctrl.

Test Plan:
- Reset, then en_i=1 with memory acking in the same cycle as the request, data 0xCC, 0x33 at addresses 0x00 and 0x01:
  - ir_wen_o pulses in cycle 2 with 0xCC and in cycle 4 with 0x33;
  - pc_o reads 0x02.
- Memory acks 3 cycles late:
  - mem_req_o and mem_addr_o stay stable for 4 cycles;
  - there is a single ir_wen_o pulse.
- stall_i=1 asserted during LOAD:
  - the fetch completes;
  - the FSM parks in IDLE with no mem_req_o until stall_i=0.
- branch_i with target 0x40 during REQ, ack data 0x99:
  - no ir_wen_o;
  - pc_o=0x40;
  - the next request uses address 0x40.
- PC=0xFF fetch completes: pc_o wraps to 0x00. Separately, rst_i pulses mid-REQ:
  - mem_req_o drops immediately;
  - pc_o returns to RESET_PC.
- With FETCH_TIMEOUT_EN and no ack for 15 cycles:
  - fault_o=1 and mem_req_o=0;
  - both hold until reset, even if en_i toggles.

Source files
------------

// File: rtl/angstrom_pkg.sv
// Shared state encoding and default widths for the instruction-fetch sequencer.
package angstrom_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    LOAD  = 2'b10,
    FAULT = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control, memory-handshake and instruction-register signals of the fetch sequencer.
interface fetch_ctrl_if #(
  parameter int ADDR_W = angstrom_pkg::DEF_ADDR_W,
  parameter int DATA_W = angstrom_pkg::DEF_DATA_W
);

  logic              en_i;
  logic              stall_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              ir_wen_o;
  logic [DATA_W-1:0] ir_d_o;
  logic [ADDR_W-1:0] pc_o;
  logic              fault_o;

  // The sequencer side
  modport master (
    input  en_i, stall_i, branch_i, branch_addr_i, mem_ack_i, mem_data_i,
    output mem_req_o, mem_addr_o, ir_wen_o, ir_d_o, pc_o, fault_o
  );

  // The memory / pipeline side
  modport slave (
    output en_i, stall_i, branch_i, branch_addr_i, mem_ack_i, mem_data_i,
    input  mem_req_o, mem_addr_o, ir_wen_o, ir_d_o, pc_o, fault_o
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: load beats increment, increment wraps modulo 2^ADDR_W.
module pc_counter
  import angstrom_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // PC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer feeding the instruction register.
// Optional fetch timeout (sticky FAULT state) is built when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl
  import angstrom_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                MAX_WAIT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_ctrl_if.master  bus
);

  fetch_state_t      r_state;
  logic              r_mem_req;
  logic              r_ir_wen;
  logic [DATA_W-1:0] r_ir_d;
  logic              r_br_pend;
  logic [ADDR_W-1:0] r_br_addr;

  logic              w_pc_load;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [ADDR_W-1:0] w_pc;
  logic              w_start;
  logic              w_redirect;

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;
`else
  logic [31:0]       w_unused_max_wait;
  assign w_unused_max_wait = 32'(MAX_WAIT);
`endif

  assign w_start    = bus.en_i & ~bus.stall_i;
  // A redirect seen in the ack cycle itself also kills the fetched byte
  assign w_redirect = r_br_pend | bus.branch_i;

  // PC update selection for the counter
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_inc  = 1'b0;
    w_pc_d    = bus.branch_addr_i;
    case (r_state)
      IDLE: w_pc_load = bus.branch_i;
      REQ: begin
        if (bus.mem_ack_i && w_redirect) begin
          w_pc_load = 1'b1;
          w_pc_d    = bus.branch_i ? bus.branch_addr_i : r_br_addr;
        end else begin
          w_pc_load = 1'b0;
        end
      end
      LOAD: begin
        w_pc_load = bus.branch_i;
        w_pc_inc  = ~bus.branch_i;
      end
      default: w_pc_load = 1'b0;
    endcase
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_d),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  // Fetch FSM with registered handshake and IR outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_ir_wen  <= 1'b0;
      r_ir_d    <= {DATA_W{1'b0}};
      r_br_pend <= 1'b0;
      r_br_addr <= {ADDR_W{1'b0}};
`ifdef FETCH_TIMEOUT_EN
      r_wait    <= {WAIT_W{1'b0}};
      r_fault   <= 1'b0;
`endif
    end else begin
      r_ir_wen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_wait    <= {WAIT_W{1'b0}};
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (bus.mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_br_pend <= 1'b0;
            if (w_redirect) begin
              r_state <= IDLE;
            end else begin
              r_state  <= LOAD;
              r_ir_wen <= 1'b1;
              r_ir_d   <= bus.mem_data_i;
            end
          end else begin
            if (bus.branch_i) begin
              r_br_pend <= 1'b1;
              r_br_addr <= bus.branch_addr_i;
            end else begin
              r_br_pend <= r_br_pend;
            end
`ifdef FETCH_TIMEOUT_EN
            if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
              r_state   <= FAULT;
              r_mem_req <= 1'b0;
              r_fault   <= 1'b1;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
`endif
          end
        end
        LOAD: begin
          if (w_start) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_wait    <= {WAIT_W{1'b0}};
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
`ifdef FETCH_TIMEOUT_EN
          r_state   <= FAULT;
          r_mem_req <= 1'b0;
          r_fault   <= 1'b1;
`else
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.mem_req_o  = r_mem_req;
  assign bus.mem_addr_o = w_pc;
  assign bus.pc_o       = w_pc;
  assign bus.ir_wen_o   = r_ir_wen;
  assign bus.ir_d_o     = r_ir_d;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fault_o    = r_fault;
`else
  assign bus.fault_o    = 1'b0;
`endif

endmodule
